// File: rtl/acc_result_apb_reader_if.sv
// APB3 completer-side bus bundle for the accelerator result reader.
interface acc_result_apb_reader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/acc_result_apb_reader.sv
// Packs the accelerator's C-matrix byte stream into a 256x32 buffer and
// exposes it, plus STATUS/CTRL, to the core over zero-wait-state APB3.
//
// state   | meaning
// EMPTY   | no bytes held since reset/CLEAR, accepting
// FILLING | some bytes held, accepting
// FULL    | N_ELEM bytes held, stream stalled until CLEAR
module acc_result_apb_reader #(
  parameter int N_ELEM         = 1024,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    acc_valid_i,
  input  logic [7:0]              acc_data_i,
  output logic                    acc_ready_o,
  output logic                    irq_o,
  acc_result_apb_reader_if.slave  apb
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  localparam logic [11:0] RES_END    = 12'(N_ELEM);
  localparam logic [11:0] ADDR_STAT  = 12'h400;
  localparam logic [11:0] ADDR_CTRL  = 12'h404;
  localparam logic [10:0] LAST_INDEX = 11'(N_ELEM - 1);

  state_t      state;
  logic [10:0] count;
  logic [31:0] mem [256];
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;

  logic [11:0] addr;
  logic        setup, access, clear, hs, we;
  logic        is_result, is_status, is_ctrl;
  logic [31:0] status_word;
  logic        unused_ok;

  assign addr      = apb.PADDR[11:0];
  assign setup     = apb.PSEL & ~apb.PENABLE;
  assign access    = apb.PSEL & apb.PENABLE;
  assign is_result = (addr[1:0] == 2'b00) && (addr < RES_END);
  assign is_status = (addr == ADDR_STAT);
  assign is_ctrl   = (addr == ADDR_CTRL);
  assign clear     = access & apb.PWRITE & is_ctrl & apb.PWDATA[0];
  assign hs        = acc_valid_i & acc_ready_o;
  assign we        = hs & ~clear & ~rst;
  assign unused_ok = ^apb.PWDATA[31:1];

  assign status_word = {5'b0, count, 14'b0, state == FILLING, state == FULL};

  // Decode is evaluated as if already in EMPTY while rst is high, so a
  // transfer straddling reset completes with the post-reset view.
  always_comb begin
    rd_err_d  = 1'b1;
    rd_data_d = 32'h0;
    if (!apb.PWRITE) begin
      if (is_result && !rst && state == FULL) begin
        rd_err_d  = 1'b0;
        rd_data_d = mem[addr[9:2]];
      end else if (is_status) begin
        rd_err_d  = 1'b0;
        rd_data_d = rst ? 32'h0 : status_word;
      end
    end else if (is_ctrl) begin
      rd_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (setup) begin
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign apb.PRDATA  = access ? rd_data_q : 32'h0;
  assign apb.PSLVERR = access ? rd_err_q : 1'b0;
  assign apb.PREADY  = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      count       <= 11'd0;
      acc_ready_o <= 1'b1;
      irq_o       <= 1'b0;
    end else begin
      irq_o <= 1'b0;
      if (clear) begin
        state       <= EMPTY;
        count       <= 11'd0;
        acc_ready_o <= 1'b1;
      end else if (hs) begin
        count <= count + 11'd1;
        if (count == LAST_INDEX) begin
          state       <= FULL;
          acc_ready_o <= 1'b0;
          irq_o       <= 1'b1;
        end else begin
          state <= FILLING;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (count[1:0] == 2'(l))
          mem[count[9:2]][8*l +: 8] <= acc_data_i;
      end
    end
  end

endmodule

// File: tb/tb_acc_result_apb_reader.sv
// Scenario bench for acc_result_apb_reader against a byte-array model.
module tb_acc_result_apb_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       acc_valid;
  logic [7:0] acc_data;
  logic       ready;
  logic       irq;

  always #5 clk = ~clk;

  acc_result_apb_reader_if #(.ADDR_WIDTH(12)) apb ();

  acc_result_apb_reader #(.N_ELEM(1024), .APB_ADDR_WIDTH(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_valid_i(acc_valid),
    .acc_data_i (acc_data),
    .acc_ready_o(ready),
    .irq_o      (irq),
    .apb        (apb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int irq_pulses = 0;

  byte unsigned model_c [1024];
  int           model_count = 0;
  bit           model_full  = 0;

  always @(negedge clk) if (irq === 1'b1) irq_pulses++;

  function automatic logic [31:0] exp_status();
    int v;
    v = model_count * 65536;
    if (model_full) v = v + 1;
    else if (model_count > 0) v = v + 2;
    return 32'(v);
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    longint v = 0;
    for (int j = 0; j < 4; j++) v = v + longint'(model_c[4*k+j]) * (longint'(1) << (8*j));
    return 32'(v);
  endfunction

  task automatic model_clear();
    model_count = 0;
    model_full  = 0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output logic rdy);
    @(negedge clk);
    apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = wd;
    @(negedge clk);
    apb.PENABLE = 1;
    #1;
    rd = apb.PRDATA; err = apb.PSLVERR; rdy = apb.PREADY;
    @(negedge clk);
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
  endtask

  // mode 0: index&0xFF, 1: constant base, 2: random, 3: base+i
  task automatic stream(input int n, input int mode, input byte unsigned base);
    int bad = 0;
    byte unsigned d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (mode)
        0: d = byte'(model_count & 255);
        1: d = base;
        2: d = byte'($urandom_range(0, 255));
        default: d = byte'(base + i);
      endcase
      acc_valid = 1; acc_data = d;
      if (ready !== 1'b1) bad++;
      if (!model_full) begin
        model_c[model_count] = d;
        model_count++;
        if (model_count == 1024) model_full = 1;
      end
    end
    @(negedge clk);
    acc_valid = 0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ready_during_stream: %0d cycles with acc_ready_o low, required 0", bad);
    end
  endtask

  task automatic check_status(input string name);
    logic [31:0] rd; logic err, rdy;
    apb_xfer(0, 12'h400, 0, rd, err, rdy);
    n_checks++;
    if (rd !== exp_status() || err !== 1'b0 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: status=%h err=%b ready=%b, required %h/0/1", name, rd, err, rdy, exp_status());
    end
  endtask

  task automatic check_word(input string name, input int k);
    logic [31:0] rd; logic err, rdy;
    apb_xfer(0, 12'(4*k), 0, rd, err, rdy);
    n_checks++;
    if (rd !== exp_word(k) || err !== 1'b0 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: word %0d = %h err=%b ready=%b, required %h/0/1", name, k, rd, err, rdy, exp_word(k));
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    model_clear();
    #1;
    n_checks++;
    if (ready !== 1'b1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b irq=%b, required 1/0", ready, irq);
    end
    n_checks++;
    if (apb.PRDATA !== 32'h0 || apb.PSLVERR !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bus: PRDATA=%h PSLVERR=%b, required 0/0", apb.PRDATA, apb.PSLVERR);
    end
    check_status("reset_status");
  endtask

  task automatic test_full_fill();
    int p0 = irq_pulses;
    stream(1024, 0, 0);
    #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_after_last: irq=%b, required 1", irq);
    end
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (irq_pulses - p0 != 1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_once: pulses=%0d ready=%b, required 1/0", irq_pulses - p0, ready);
    end
    check_status("full_status");
    check_word("word_first", 0);
    check_word("word_last", 255);
    for (int i = 0; i < 12; i++) check_word("word_random", int'($urandom_range(0, 255)));
  endtask

  task automatic test_clear_in_full();
    logic [31:0] rd; logic err, rdy;
    int p0;
    apb_xfer(1, 12'h404, 32'h0, rd, err, rdy);
    check_status("ctrl0_no_effect");
    apb_xfer(1, 12'h404, 32'h1, rd, err, rdy);
    model_clear();
    #1;
    n_checks++;
    if (err !== 1'b0 || ready !== 1'b1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_full: err=%b ready=%b irq=%b, required 0/1/0", err, ready, irq);
    end
    check_status("status_after_clear");
    p0 = irq_pulses;
    stream(1024, 1, 8'h55);
    repeat (3) @(negedge clk);
    n_checks++;
    if (irq_pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL irq_refill: pulses=%0d, required 1", irq_pulses - p0);
    end
    check_word("refill_word4", 4);
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic err, rdy;
    apb_xfer(1, 12'h404, 32'h1, rd, err, rdy);
    model_clear();
    stream(5, 3, 8'hA0);
    apb_xfer(0, 12'h000, 0, rd, err, rdy);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_not_full: PRDATA=%h err=%b ready=%b, required 0/1/1", rd, err, rdy);
    end
    check_status("partial_status");
  endtask

  task automatic test_clear_race();
    logic [31:0] rd; logic err, rdy;
    apb_xfer(1, 12'h404, 32'h1, rd, err, rdy);
    model_clear();
    stream(100, 2, 0);
    check_status("count_100");
    @(negedge clk);
    apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = 12'h404; apb.PWDATA = 32'h1;
    @(negedge clk);
    apb.PENABLE = 1; acc_valid = 1; acc_data = 8'hEE;
    @(negedge clk);
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; acc_valid = 0;
    model_clear();
    check_status("clear_wins");
    stream(1, 1, 8'h77);
    stream(1023, 2, 0);
    check_word("race_word0", 0);
    check_word("race_word1", 1);
    apb_xfer(0, 12'h000, 0, rd, err, rdy);
    n_checks++;
    if (rd[7:0] !== 8'h77) begin
      n_fail++;
      $display("FAIL race_lane0: lane0=%h, required 77", rd[7:0]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err, rdy;
    logic [12:0] tbl [7];
    tbl[0] = {1'b1, 12'h000}; tbl[1] = {1'b0, 12'h404}; tbl[2] = {1'b0, 12'h800};
    tbl[3] = {1'b1, 12'h800}; tbl[4] = {1'b1, 12'h400}; tbl[5] = {1'b0, 12'h002};
    tbl[6] = {1'b1, 12'h3FC};
    for (int i = 0; i < 7; i++) begin
      apb_xfer(tbl[i][12], tbl[i][11:0], $urandom, rd, err, rdy);
      n_checks++;
      if (err !== 1'b1 || rd !== 32'h0 || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL err_access_%0d: addr=%h wr=%b PRDATA=%h err=%b ready=%b, required 0/1/1",
                 i, tbl[i][11:0], tbl[i][12], rd, err, rdy);
      end
    end
    check_status("status_after_errors");
    check_word("word0_after_err_write", 0);
    check_word("word255_after_err_write", 255);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err;
    @(negedge clk);
    rst = 1;
    apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 12'h000;
    @(negedge clk);
    rst = 0; apb.PENABLE = 1;
    model_clear();
    #1;
    rd = apb.PRDATA; err = apb.PSLVERR;
    @(negedge clk);
    apb.PSEL = 0; apb.PENABLE = 0;
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_across_reset: PRDATA=%h err=%b ready=%b, required 0/1/1", rd, err, ready);
    end
    check_status("status_after_reset_full");
    stream(37, 2, 0);
    check_status("status_mid_fill");
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    model_clear();
    check_status("status_after_reset_fill");
  endtask

  initial begin
    rst = 1; acc_valid = 0; acc_data = 0;
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
    test_reset();
    test_full_fill();
    test_clear_in_full();
    test_partial();
    test_clear_race();
    test_errors();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_result_apb_reader.md
Name: acc_result_apb_reader

Overview:
- Result-side bus interface of the matrix accelerator: the reader for the result matrix C that the accelerator produces.
- Accepts C elements (8-bit) from the accelerator as a valid/ready byte stream and packs them little-endian into a 256x32 result buffer.
- Lets the core read the buffer, a status register and a control register over APB3.
- Sits between the accelerator datapath and the APB peripheral bus, alongside the operand-load interface.

Parameters:
- N_ELEM, 1024, number of C elements per result; multiple of 4, max 1024.
- APB_ADDR_WIDTH, 12, PADDR width; decoding uses PADDR[11:0].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- acc_valid_i  in  1  result byte valid from accelerator
- acc_data_i  in  8  result byte, C element in row-major order
- acc_ready_o  out  1  buffer accepts a byte this cycle
- PADDR  in  APB_ADDR_WIDTH  APB address, byte-addressed, word-aligned
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready; always 1, zero wait states
- PSLVERR  out  1  APB error
- irq_o  out  1  one-cycle pulse when buffer becomes full

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: acc_ready_o=1, PRDATA=0, PSLVERR=0, irq_o=0, state=EMPTY, count=0. Buffer RAM is not reset.
- Address map, word-aligned:
  - 0x000..(N_ELEM-4): RESULT words, read-only. Word k = {C[4k+3],C[4k+2],C[4k+1],C[4k]}.
  - 0x400: STATUS, read-only. bit0=FULL, bit1=FILLING, bits[26:16]=count (11 bits), other bits 0.
  - 0x404: CTRL, write-only. Writing bit0=1 issues CLEAR; bit0=0 has no effect; reads return 0.
  - Any other offset is unmapped.
- State machine:
  - EMPTY: acc_ready_o=1. A handshake (acc_valid_i & acc_ready_o) stores the byte at index count, count++, and moves to FILLING.
  - FILLING: acc_ready_o=1. Each handshake stores the byte at index count and count++. When the accepted byte is index N_ELEM-1: move to FULL, count=N_ELEM, irq_o=1 in the following cycle only.
  - FULL: acc_ready_o=0 and no bytes are accepted. Leave only on CLEAR or rst.
  - CLEAR from any state: next state EMPTY, count=0. The handshake byte in the same cycle is dropped (CLEAR wins). irq_o is not raised. RAM contents are retained.
- Byte store: write index count into word count>>2, lane count[1:0], using a per-byte lane enable. Count is 11 bits and saturates at N_ELEM.
- APB timing:
  - Setup phase (PSEL & !PENABLE) performs the RAM read.
  - Access phase (PSEL & PENABLE) drives PRDATA/PSLVERR combinationally from the registered read data and decode. PREADY=1.
  - PRDATA is 0 and PSLVERR is 0 outside the access phase.
- Error rules: PSLVERR=1 with PRDATA=0 for:
  - a read of RESULT while state!=FULL;
  - a write to RESULT or STATUS;
  - a read of CTRL;
  - any unmapped access.
  Error writes have no side effect.
- CTRL write takes effect at the access-phase clock edge.
- A STATUS read returns the value registered at the setup-phase edge.
- Reset mid-fill: state EMPTY and count 0 on the next edge. A RESULT read issued during reset returns the error response after reset deasserts.

Test Plan:
- Reset, then read 0x400 -> PRDATA=0x00000000, PSLVERR=0. Check acc_ready_o=1 and irq_o=0.
- Stream bytes i&0xFF for i=0..1023 with acc_valid_i held at 1 -> irq_o pulses exactly once, one cycle after byte 1023. acc_ready_o=0 afterwards. STATUS=0x04000001. Word 0x000=0x03020100. Word 0x3FC=0xFFFEFDFC.
- Stream 5 bytes (0xA0..0xA4), then read 0x000 -> PSLVERR=1, PRDATA=0. STATUS=0x00050002.
- In FULL, write CTRL=1 -> STATUS=0. acc_ready_o=1 next cycle. Refill with 0x55 -> word 0x010=0x55555555.
- During FILLING at count=100, assert CTRL=1 in the same cycle as a handshake -> the byte is dropped and count=0. The next byte, 0x77, lands in word 0 lane 0.
- Write to 0x000, read 0x404, and access 0x800 -> PSLVERR=1 on each. STATUS unchanged. PREADY=1 in every access phase.
